// File: rtl/uart_echo_fifo_if.sv
// uart_echo_fifo_if: serial lines and status of the UART echo buffer.
//   slave  : the echo block (consumes rx, drives tx and status)
//   master : whoever drives rx and watches tx/status
//   rx, tx            serial in / out, idle high
//   rx_busy, tx_busy  receiver in frame / drain or frame in progress
//   count             FIFO occupancy, 0..DEPTH
//   frame_err         one-cycle pulse on a low stop bit
//   overflow          sticky, word dropped on full FIFO
interface uart_echo_fifo_if #(
  parameter int DEPTH = 8
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             rx;
  logic             tx;
  logic             rx_busy;
  logic             tx_busy;
  logic [CNT_W-1:0] count;
  logic             frame_err;
  logic             overflow;

  modport slave  (input rx, output tx, rx_busy, tx_busy, count, frame_err, overflow);
  modport master (output rx, input tx, rx_busy, tx_busy, count, frame_err, overflow);
endinterface

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: UART receiver -> DEPTH-entry FIFO -> UART transmitter.
// Buffered words are retransmitted in order once rx has been idle for
// IDLE_BITS bit times (IDLE_BITS = 0 echoes whenever the FIFO holds data).
// Ports:
//   clk   system clock, rising edge
//   nrst  asynchronous active-low reset
//   bus   uart_echo_fifo_if.slave (rx, tx, rx_busy, tx_busy, count,
//         frame_err, overflow)
module uart_echo_fifo #(
  parameter int CLK_FREQ  = 12000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 8,
  parameter int IDLE_BITS = 45
) (
  input  logic             clk,
  input  logic             nrst,
  uart_echo_fifo_if.slave  bus
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int DW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int IW  = $clog2(IDLE_BITS + 2);  // >= 1 bit even for IDLE_BITS = 0

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [DW-1:0] HALF_LAST = DW'(DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_BITS);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_e;

  // ---------------- rx synchronizer ----------------
  logic rx_meta, rx_s;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) {rx_meta, rx_s} <= 2'b11;
    else       {rx_meta, rx_s} <= {bus.rx, rx_meta};

  // ---------------- FIFO state (shared) ----------------
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 full, empty, push, pop, drop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // ---------------- RX FSM ----------------
  uart_st_e             rx_st, rx_st_nx;
  logic [DW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_tick, start_det, stop_smp;

  always_comb begin
    rx_st_nx  = rx_st;
    rx_tick   = 1'b0;
    start_det = 1'b0;
    stop_smp  = 1'b0;
    case (rx_st)
      S_IDLE:  if (!rx_s) begin
                 start_det = 1'b1;
                 rx_st_nx  = S_START;
               end
      S_START: begin
                 // mid start bit: a high line here was a glitch
                 rx_tick = (rx_cnt == HALF_LAST);
                 if (rx_tick) rx_st_nx = rx_s ? S_IDLE : S_DATA;
               end
      S_DATA:  begin
                 rx_tick = (rx_cnt == DIV_LAST);
                 if (rx_tick && rx_bit == BIT_LAST) rx_st_nx = S_STOP;
               end
      S_STOP:  begin
                 rx_tick = (rx_cnt == DIV_LAST);
                 if (rx_tick) begin
                   stop_smp = 1'b1;
                   rx_st_nx = S_IDLE;
                 end
               end
      default: rx_st_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst)
    if (!nrst) rx_st <= S_IDLE;
    else       rx_st <= rx_st_nx;

  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      if (rx_st == S_IDLE || rx_tick) rx_cnt <= '0;
      else                            rx_cnt <= rx_cnt + 1'b1;
      if (rx_st != S_DATA) rx_bit <= '0;
      else if (rx_tick)    rx_bit <= rx_bit + 1'b1;
      if (rx_st == S_DATA && rx_tick) rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
    end

  // A pop on the same cycle frees the slot, so a full FIFO still accepts.
  assign push = stop_smp && rx_s && (!full || pop);
  assign drop = stop_smp && rx_s && full && !pop;

  logic frame_err_q, overflow_q;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      frame_err_q <= stop_smp && !rx_s;
      overflow_q  <= overflow_q | drop;
    end

  // ---------------- idle timer ----------------
  logic [DW-1:0] idle_div;
  logic [IW-1:0] idle_cnt;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      idle_div <= '0;
      idle_cnt <= '0;
    end else if (start_det) begin
      idle_div <= '0;
      idle_cnt <= '0;
    end else if (rx_st == S_IDLE && rx_s) begin
      if (idle_div == DIV_LAST) begin
        idle_div <= '0;
        if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
      end else begin
        idle_div <= idle_div + 1'b1;
      end
    end

  // ---------------- TX FSM ----------------
  uart_st_e             tx_st, tx_st_nx;
  logic [DW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_tick, tx_stop_end, drain;

  always_comb begin
    tx_st_nx    = tx_st;
    pop         = 1'b0;
    tx_stop_end = 1'b0;
    tx_tick     = (tx_cnt == DIV_LAST);
    case (tx_st)
      S_IDLE:  if (drain && !empty) begin
                 pop      = 1'b1;
                 tx_st_nx = S_START;
               end
      S_START: if (tx_tick) tx_st_nx = S_DATA;
      S_DATA:  if (tx_tick && tx_bit == BIT_LAST) tx_st_nx = S_STOP;
      S_STOP:  if (tx_tick) begin
                 tx_stop_end = 1'b1;
                 // chain straight into the next frame with no idle gap
                 if (drain && !empty) begin
                   pop      = 1'b1;
                   tx_st_nx = S_START;
                 end else begin
                   tx_st_nx = S_IDLE;
                 end
               end
      default: tx_st_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst)
    if (!nrst) tx_st <= S_IDLE;
    else       tx_st <= tx_st_nx;

  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else begin
      if (tx_st == S_IDLE || tx_tick) tx_cnt <= '0;
      else                            tx_cnt <= tx_cnt + 1'b1;
      if (tx_st != S_DATA) tx_bit <= '0;
      else if (tx_tick)    tx_bit <= tx_bit + 1'b1;
      if (pop)                             tx_sh <= mem[rd_ptr];
      else if (tx_st == S_DATA && tx_tick) tx_sh <= tx_sh >> 1;
    end

  // Drain runs until a stop bit finishes with nothing left to send.
  always_ff @(posedge clk or negedge nrst)
    if (!nrst)                                        drain <= 1'b0;
    else if (idle_cnt == IDLE_MAX && !empty && !drain) drain <= 1'b1;
    else if (tx_stop_end && empty)                     drain <= 1'b0;

  // ---------------- FIFO storage ----------------
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= rx_sh;

  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end

  // ---------------- outputs ----------------
  always_comb begin
    case (tx_st)
      S_START: bus.tx = 1'b0;
      S_DATA:  bus.tx = tx_sh[0];
      default: bus.tx = 1'b1;
    endcase
  end

  assign bus.rx_busy   = (rx_st != S_IDLE);
  assign bus.tx_busy   = drain | (tx_st != S_IDLE);
  assign bus.count     = count;
  assign bus.frame_err = frame_err_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

Parametrised UART receive-buffer-retransmit block: receives asynchronous serial frames on `rx` and stores the data words in a DEPTH-entry FIFO. It retransmits the buffered words on `tx`, in order, once the line has been idle for a programmable number of bit times. It is the successor to the team's fixed 8-byte/9600-baud loopback buffer, with these additions:

- configurable baud, data width, depth and idle timeout;
- mid-bit sampling;
- framing-error and overflow detection;
- concurrent receive while transmitting.

## Interface
Parameters:
- `CLK_FREQ`, 12000000, clock frequency in Hz
- `BAUD`, 9600, bit rate; DIV = CLK_FREQ/BAUD (integer division) clocks per bit, DIV >= 4
- `DATA_BITS`, 8, data bits per frame (5..9)
- `DEPTH`, 8, FIFO entries, power of two >= 2
- `IDLE_BITS`, 45, idle bit times before flush; 0 = streaming echo (transmit whenever FIFO non-empty)

Ports:
- `clk` input 1: system clock, rising edge
- `nrst` input 1: asynchronous active-low reset
- `rx` input 1: serial in, idle high, asynchronous to `clk`
- `tx` output 1: serial out, idle high
- `rx_busy` output 1: receiver inside a frame
- `tx_busy` output 1: drain in progress or frame being sent
- `count` output $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH
- `frame_err` output 1: one-cycle pulse, stop bit sampled low
- `overflow` output 1: sticky, a word was dropped on full FIFO

## Operation
- Reset is asynchronous: all outputs 0 except `tx` = 1. FIFO is emptied, idle counter cleared, drain flag cleared.
- `rx` passes through a 2-flop synchronizer; all RX logic uses the synchronized value.

RX FSM (states IDLE -> START -> DATA -> STOP):
- IDLE -> START on a synchronized low.
- In START, sample at DIV/2 clocks:
  - low -> DATA;
  - high -> IDLE (glitch rejected, nothing stored).
- In DATA, sample every DIV clocks, LSB first, DATA_BITS samples, then -> STOP.
- In STOP, sample after DIV clocks:
  - high and FIFO not full -> write word;
  - high and full -> drop word and set `overflow`;
  - low -> pulse `frame_err`, discard word.
- STOP returns to IDLE in all cases at the stop sample.

Idle counter:
- Increments once per DIV clocks while RX is in IDLE and the line is high.
- Saturates at IDLE_BITS.
- Clears to 0 on start detection.

Drain flag:
- Set when the idle counter equals IDLE_BITS, FIFO count > 0, and the drain flag is clear.
- Cleared when a TX stop bit completes with FIFO empty.
- With IDLE_BITS = 0 the condition reduces to FIFO non-empty.

TX FSM (states IDLE -> START -> DATA -> STOP):
- Leaves IDLE when the drain flag is set and FIFO is non-empty; pops the head word on that cycle.
- Sends start (0), DATA_BITS data LSB first, then stop (1), each for exactly DIV clocks.
- After stop: if FIFO is non-empty and the drain flag is set, the next frame starts with no gap; otherwise -> IDLE.
- RX continues during TX. Words received during a drain are appended and sent in the same drain.

FIFO and status outputs:
- Circular buffer; read/write pointers wrap modulo DEPTH.
- Simultaneous write and pop: both occur and `count` is unchanged. A write to a full FIFO on the same cycle as a pop succeeds with no overflow.
- `overflow` clears only on reset.
- `rx_busy` = RX state != IDLE.
- `tx_busy` = drain flag OR TX state != IDLE.

## Timing
- Start detection occurs 2 clocks after the `rx` falling edge (synchronizer), plus 1 clock to register.
- FIFO write occurs on the stop-sample edge; `count` updates on the next edge.
- `frame_err` is high for exactly 1 clock, on the cycle after the stop sample.
- Drain flag sets 1 clock after the idle counter reaches IDLE_BITS.
- `tx` falls, and `count` decrements, 1 clock after the drain flag sets.
- Frame length on `tx` is exactly (DATA_BITS+2)·DIV clocks; back-to-back frames have zero idle clocks.
- Reset mid-frame: `tx` goes to 1 immediately (asynchronous); no partial frame resumes after reset release.

## Test plan
Bench uses CLK_FREQ=160, BAUD=10 (DIV=16), DATA_BITS=8, DEPTH=8, IDLE_BITS=45 unless stated.
1. Send 0xA5, then hold `rx` high -> `count` goes 1. After 45·16 = 720 clocks of idle, `tx` emits 0xA5 (start, 1,0,1,0,0,1,0,1, stop) over 160 clocks; `count` returns to 0; `tx_busy` drops after the stop bit.
2. Send 0x01, 0x80, 0xFF back-to-back -> `count` peaks at 3; after the idle timeout, three contiguous 160-clock frames are emitted in order 0x01, 0x80, 0xFF.
3. Send 9 bytes 0x10..0x18 -> `overflow` = 1 after the 9th stop bit; 0x10..0x17 are echoed and 0x18 is absent; `overflow` stays 1 after the drain.
4. Send a frame with data 0x3C and stop bit 0 -> `frame_err` high for 1 clock; `count` stays 0; no TX output. A following valid 0x42 is received and echoed normally.
5. Pulse `rx` low for 5 clocks (< DIV/2) -> no word stored, `rx_busy` returns 0, `count` = 0. Separately, assert `nrst` low mid-TX-frame -> `tx` = 1 immediately, `count` = 0, no output after release.
6. IDLE_BITS=0: send 0x55 -> `tx` start bit begins 1-2 clocks after the stop sample (FIFO write, then drain). While 0x55 is being sent, receive 0xAA -> 0xAA follows with no gap.
